md5_block_former: RTL and testbench
===================================

Name: md5_block_former

Overview:
- Sits directly downstream of GuessGenerator and upstream of the MD5 hash core.
- Converts each 128-bit candidate guess into a single padded 512-bit MD5 message block: message bytes, 0x80 terminator, zero fill, 64-bit little-endian bit length.
- Buffers formatted blocks in a small FIFO, back-pressures the generator, counts blocks delivered, and signals completion once the generator is done and the buffer has drained.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 48, width of the delivered-block counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; also the configuration load strobe
- guesslen  in  5  guess length in characters; sampled only on clk edges where reset=1
- guess  in  128  candidate; character i at guess[127-8i -: 8], first character in the MSB byte
- guess_valid  in  1  guess holds a new candidate this cycle
- gen_done  in  1  generator has produced its final candidate
- gen_stall  out  1  generator must hold off; combinational, = (fifo_count >= DEPTH-1)
- block  out  512  formatted block at FIFO head; byte k at block[8k+7:8k]
- block_valid  out  1  FIFO not empty
- block_ready  in  1  hash core accepts the head block this cycle
- block_count  out  CNT_W  number of blocks popped since reset
- overflow  out  1  sticky: a guess_valid arrived while the FIFO was full
- len_err  out  1  latched length is 0 or greater than 16
- all_done  out  1  sticky: generator done and every block delivered

Behaviour:
- Reset, any edge with reset=1:
  - len_q <= guesslen.
  - FIFO emptied.
  - block_count, overflow, all_done, and the done_seen flag cleared.
  - len_err <= (guesslen==0 || guesslen>16).
  - Reset mid-operation discards all buffered blocks. The block output after reset is don't-care while block_valid=0.
- Outputs in the first cycle after reset: block_valid=0, gen_stall=0, block_count=0, overflow=0, all_done=0.
- Formatting is combinational on the push path, written into the FIFO on the push edge. With L=len_q, for byte k of 0..63:
  - k<L: guess byte k.
  - k==L: 0x80.
  - L<k<56: 0x00.
  - byte 56 = (8L) & 0xFF.
  - byte 57 = (8L)>>8, which is 0 for all L≤16.
  - bytes 58..63 = 0x00.
  - Guess bytes at index ≥L are ignored.
- Push when guess_valid=1, len_err=0, and (FIFO not full, or a pop occurs in the same cycle).
- Push attempted while full with no pop: guess dropped, overflow <= 1.
- Any push while len_err=1: ignored; overflow is unaffected.
- Pop when block_valid=1 and block_ready=1. block_count increments on each pop and wraps modulo 2^CNT_W.
- Latency: a guess pushed at edge N appears at block with block_valid=1 after edge N, provided the FIFO was empty. Ordering is strict FIFO.
- Simultaneous push and pop:
  - When empty: both occur only if already valid. Because block_valid=0, no pop happens and the push lands.
  - When full: both succeed and the count is unchanged.
- gen_stall asserts at DEPTH-1 occupancy. This leaves one slot for a guess already in flight during the generator's one-cycle stall response.
- Completion:
  - done_seen <= 1 when gen_done=1 (sticky).
  - all_done <= 1 on the first edge where done_seen=1, FIFO empty, and no push is pending.
  - all_done stays set until reset.
  - If len_err=1, all_done asserts one cycle after done_seen, since nothing is buffered.
- block_ready with block_valid=0 has no effect.

Test Plan:
- Reset with guesslen=2, then push guess=0x6162_0000…0 and hold block_ready=1. Required, one cycle after the push:
  - block_valid=1.
  - block[7:0]=0x61, [15:8]=0x62, [23:16]=0x80.
  - [455:448]=0x10.
  - All other bytes 0.
  - block_count=1 after the next edge.
- Reset with guesslen=16, push an all-0x7A guess. Required:
  - bytes 0..15 = 0x7A.
  - byte 16 = 0x80.
  - byte 56 = 0x80, byte 57 = 0x00.
  - bytes 17..55 and 58..63 = 0.
- Backpressure with block_ready=0 and DEPTH=4, five consecutive pushes. Required:
  - gen_stall=1 after the 3rd push.
  - The 4th push is accepted.
  - The 5th push is dropped and overflow=1.
  - Then hold block_ready=1: exactly 4 blocks pop in push order and block_count=4.
- Full FIFO with push and pop in the same cycle. Required: count stays 4, overflow stays 0, and the new block emerges last.
- gen_done pulsed while 2 blocks are buffered. Required:
  - all_done stays 0 until the second pop.
  - all_done goes to 1 on the following edge and stays high.
  - Asserting reset then clears all outputs on that edge.
- Reset with guesslen=0, and separately with guesslen=17. Required:
  - len_err=1.
  - Pushes are ignored and block_valid stays 0.
  - gen_done gives all_done=1 two edges later.

Source files
------------

// File: rtl/md5_block_former.sv
// md5_block_former: turns each 128-bit candidate guess into one padded
// 512-bit MD5 message block, buffers blocks in a small FIFO, applies
// back-pressure to the guess generator and reports completion.
module md5_block_former #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       guesslen,
  input  logic [127:0]     guess,
  input  logic             guess_valid,
  input  logic             gen_done,
  output logic             gen_stall,
  output logic [511:0]     block,
  output logic             block_valid,
  input  logic             block_ready,
  output logic [CNT_W-1:0] block_count,
  output logic             overflow,
  output logic             len_err,
  output logic             all_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]    len_q;
  logic          done_seen;
  logic [511:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [511:0]  fmt;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push;
  logic          pop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign block_valid = !empty;
  assign gen_stall   = (count >= CW'(DEPTH - 1));
  assign block       = mem[rd_ptr];

  assign pop      = block_valid && block_ready;
  assign push_req = guess_valid && !len_err;
  // A full FIFO still accepts a guess when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  // Build the padded block: message bytes, 0x80 terminator, zero fill and
  // the bit length in bytes 56..63 (only byte 56 can be non-zero for L<=16).
  always_comb begin
    fmt = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(len_q)) fmt[8*k +: 8] = guess[127-8*k -: 8];
    end
    for (int k = 0; k <= 16; k++) begin
      if (k == int'(len_q)) fmt[8*k +: 8] = 8'h80;
    end
    fmt[455:448] = {len_q, 3'b000};
  end

  // FIFO storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fmt;
  end

  // Control state: configuration load, FIFO pointers, counters and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= guesslen;
      len_err     <= (guesslen == 5'd0) || (guesslen > 5'd16);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      block_count <= '0;
      overflow    <= 1'b0;
      done_seen   <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        block_count <= block_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      if (gen_done) done_seen <= 1'b1;
      if (done_seen && empty && !push) all_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md5_block_former.sv
// tb_md5_block_former: directed stimulus with a block scoreboard; a forked
// monitor compares every block popped by the DUT against the queue head.
module tb_md5_block_former;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   guesslen;
  logic [127:0] guess;
  logic         guess_valid;
  logic         gen_done;
  logic         gen_stall;
  logic [511:0] block;
  logic         block_valid;
  logic         block_ready;
  logic [47:0]  block_count;
  logic         overflow;
  logic         len_err;
  logic         all_done;

  int checks = 0;
  int errors = 0;
  int cur_len = 0;
  logic [511:0] sb [$];

  md5_block_former #(.DEPTH(4), .CNT_W(48)) dut (
    .clk(clk), .reset(reset), .guesslen(guesslen), .guess(guess),
    .guess_valid(guess_valid), .gen_done(gen_done), .gen_stall(gen_stall),
    .block(block), .block_valid(block_valid), .block_ready(block_ready),
    .block_count(block_count), .overflow(overflow), .len_err(len_err),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  // Reference padding: message bytes, terminator, zero fill, bit length.
  function automatic logic [511:0] build(input int l, input logic [127:0] g);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < l; k++) b[8*k +: 8] = g[127-8*k -: 8];
    b[8*l +: 8] = 8'h80;
    b[455:448] = 8'(8 * l);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int len);
    reset = 1'b1;
    guesslen = 5'(len);
    guess_valid = 1'b0;
    gen_done = 1'b0;
    block_ready = 1'b0;
    cur_len = len;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_guess(input logic [127:0] g, input bit accept);
    guess = g;
    guess_valid = 1'b1;
    if (accept) sb.push_back(build(cur_len, g));
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (block_count != 48'(target) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(block_count), 64'(target));
  endtask

  initial begin
    logic [511:0] e;
    reset = 1'b1;
    guesslen = 5'd2;
    guess = '0;
    guess_valid = 1'b0;
    gen_done = 1'b0;
    block_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!reset && block_valid && block_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h expected none", block);
          end else begin
            e = sb.pop_front();
            if (block !== e) begin
              errors++;
              $display("FAIL sb_block: got %h expected %h", block, e);
            end
          end
        end
      end
    join_none

    // Reset state
    do_reset(2);
    check("rst_valid", 64'(block_valid), 0);
    check("rst_stall", 64'(gen_stall), 0);
    check("rst_count", 64'(block_count), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_all_done", 64'(all_done), 0);
    check("rst_len_err", 64'(len_err), 0);

    // "ab", L=2: hand-built expected block
    block_ready = 1'b1;
    guess = 128'h6162_0000_0000_0000_0000_0000_0000_0000;
    guess_valid = 1'b1;
    e = '0;
    e[7:0] = 8'h61;
    e[15:8] = 8'h62;
    e[23:16] = 8'h80;
    e[455:448] = 8'h10;
    sb.push_back(e);
    tick();
    guess_valid = 1'b0;
    check("ab_valid", 64'(block_valid), 1);
    tick();
    check("ab_count", 64'(block_count), 1);
    check("ab_empty", 64'(block_valid), 0);

    // L=16, all 'z'
    do_reset(16);
    block_ready = 1'b1;
    guess = {16{8'h7A}};
    guess_valid = 1'b1;
    e = '0;
    for (int k = 0; k < 16; k++) e[8*k +: 8] = 8'h7A;
    e[135:128] = 8'h80;
    e[455:448] = 8'h80;
    sb.push_back(e);
    tick();
    guess_valid = 1'b0;
    check("z16_valid", 64'(block_valid), 1);
    tick();
    check("z16_count", 64'(block_count), 1);

    // Backpressure: five pushes into a DEPTH=4 FIFO with the sink stalled
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      drive_guess({8'(65 + i), 8'(97 + i), 112'h0}, i < 4);
      tick();
      if (i == 1) check("bp_stall_2", 64'(gen_stall), 0);
      if (i == 2) check("bp_stall_3", 64'(gen_stall), 1);
      if (i == 3) check("bp_ovf_4", 64'(overflow), 0);
    end
    guess_valid = 1'b0;
    check("bp_overflow", 64'(overflow), 1);
    block_ready = 1'b1;
    wait_count(4, 20, "bp_drain_count");
    tick();
    check("bp_drain_count_hold", 64'(block_count), 4);
    check("bp_empty", 64'(block_valid), 0);

    // Full FIFO with simultaneous push and pop
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      drive_guess({8'(48 + i), 8'(49 + i), 8'(50 + i), 104'h0}, 1'b1);
      tick();
    end
    drive_guess(128'h7879_7A00_0000_0000_0000_0000_0000_0000, 1'b1);
    block_ready = 1'b1;
    tick();
    guess_valid = 1'b0;
    check("pp_overflow", 64'(overflow), 0);
    check("pp_stall_full", 64'(gen_stall), 1);
    check("pp_count", 64'(block_count), 1);
    wait_count(5, 20, "pp_drain_count");
    check("pp_overflow_after", 64'(overflow), 0);

    // Completion with two blocks buffered
    do_reset(2);
    for (int i = 0; i < 2; i++) begin
      drive_guess({8'(80 + i), 8'(81 + i), 112'h0}, 1'b1);
      tick();
    end
    guess_valid = 1'b0;
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    check("dn_held", 64'(all_done), 0);
    block_ready = 1'b1;
    tick();
    check("dn_pop1", 64'(all_done), 0);
    tick();
    check("dn_pop2", 64'(all_done), 0);
    check("dn_count", 64'(block_count), 2);
    tick();
    check("dn_set", 64'(all_done), 1);
    tick();
    check("dn_sticky", 64'(all_done), 1);
    reset = 1'b1;
    tick();
    check("dn_rst_all_done", 64'(all_done), 0);
    check("dn_rst_count", 64'(block_count), 0);
    check("dn_rst_valid", 64'(block_valid), 0);
    check("dn_rst_overflow", 64'(overflow), 0);
    reset = 1'b0;

    // Illegal lengths
    for (int j = 0; j < 2; j++) begin
      do_reset(j == 0 ? 0 : 17);
      check("le_flag", 64'(len_err), 1);
      block_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        drive_guess({16{8'h55}}, 1'b0);
        tick();
      end
      guess_valid = 1'b0;
      check("le_valid", 64'(block_valid), 0);
      check("le_overflow", 64'(overflow), 0);
      gen_done = 1'b1;
      tick();
      gen_done = 1'b0;
      check("le_done_early", 64'(all_done), 0);
      tick();
      check("le_done", 64'(all_done), 1);
    end

    check("sb_leftover", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
